// File: rtl/shift_delay_var.sv
// Multi-lane variable-depth delay line.
// All lanes share one delay select and one valid tag per stage. The output
// tap moves as soon as a new delay is accepted. dout_valid is then masked for
// the new delay's worth of enabled cycles, which hides the samples that the
// tap jump would otherwise duplicate or skip.
module shift_delay_var #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    localparam int DLY_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [DLY_W-1:0]          dly,
    input  logic                      din_valid,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic                      dout_valid,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dly_err
);

    localparam int DW = CHANNELS * WIDTH;

    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] settle_q;
    logic             dly_err_q;

    logic [DLY_W-1:0] dly_eff;
    logic             err_eff;
    logic [DLY_W-1:0] tap;
    logic             vld_sel;

    // Clamp the requested delay into 1..DEPTH and flag any out-of-range request
    always_comb begin
        dly_eff = dly;
        err_eff = 1'b0;
        if (dly == '0) begin
            dly_eff = DLY_W'(1);
            err_eff = 1'b1;
        end else if (dly > DLY_W'(DEPTH)) begin
            dly_eff = DLY_W'(DEPTH);
            err_eff = 1'b1;
        end
    end

    // Data stages: shift on enable, never cleared by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (en) begin
            data_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Valid tags: shift alongside data, flush clears them all, including the
    // sample entering in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (en) begin
            if (flush) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= din_valid;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end
    end

    // Delay register, range flag, and settle counter that restarts on a delay change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly_q     <= DLY_W'(1);
            settle_q  <= '0;
            dly_err_q <= 1'b0;
        end else if (en) begin
            dly_err_q <= err_eff;
            if (dly_eff != dly_q) begin
                dly_q    <= dly_eff;
                settle_q <= dly_eff;
            end else if (settle_q != '0) begin
                settle_q <= settle_q - 1'b1;
            end
        end
    end

    assign tap = dly_q - 1'b1;

    // Output tap mux, driven from registers only
    always_comb begin
        dout    = '0;
        vld_sel = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (tap == DLY_W'(i)) begin
                dout    = data_q[i];
                vld_sel = vld_q[i];
            end
        end
    end

    assign dout_valid = vld_sel & (settle_q == '0);
    assign dly_err    = dly_err_q;

endmodule

// File: tb/tb_shift_delay_var.sv
// Scoreboard bench for shift_delay_var. The reference model keeps a history
// of every accepted sample, indexed by enabled-cycle number. The expected
// output is simply the sample taken d enabled cycles back. That sample is
// valid only if it came after the most recent flush/reset, and only when the
// last delay change is at least d enabled cycles old.
module tb_shift_delay_var;

    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int DEP = 16;
    localparam int DLW = $clog2(DEP + 1);
    localparam int DW  = W * CH;
    localparam int HMAX = 8192;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic           flush = 1'b0;
    logic [DLW-1:0] dly = DLW'(1);
    logic           din_valid = 1'b0;
    logic [DW-1:0]  din = '0;
    logic           dout_valid;
    logic [DW-1:0]  dout;
    logic           dly_err;

    shift_delay_var #(
        .WIDTH(W),
        .CHANNELS(CH),
        .DEPTH(DEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .flush(flush),
        .dly(dly),
        .din_valid(din_valid),
        .din(din),
        .dout_valid(dout_valid),
        .dout(dout),
        .dly_err(dly_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int            n = 0;
    int            reset_mark = 0;
    int            flush_mark = 0;
    int            mdly = 1;
    int            chg_n = 0;
    int            chg_d = 0;
    bit            merr = 1'b0;
    logic [DW-1:0] hist_d [HMAX];
    bit            hist_v [HMAX];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t r;
        int   idx;
        int   settle;
        idx    = n - mdly + 1;
        settle = chg_d - (n - chg_n);
        if (settle < 0) settle = 0;
        r.e = merr;
        if (idx <= reset_mark) begin
            r.d = '0;
            r.v = 1'b0;
        end else begin
            r.d = hist_d[idx];
            r.v = hist_v[idx] && (idx > flush_mark) && (settle == 0);
        end
        return r;
    endfunction

    // One clock: apply inputs, let the edge happen, advance the model, queue expectation
    task automatic step(input bit e_i, input bit f_i, input bit v_i,
                        input logic [DW-1:0] d_i, input int dly_i);
        int dv;
        int d;
        bit er;
        #1;
        en        = e_i;
        flush     = f_i;
        din_valid = v_i;
        din       = d_i;
        dly       = DLW'(dly_i);
        @(posedge clk);
        if (e_i) begin
            dv = int'(dly);
            if (dv == 0) begin
                d = 1; er = 1'b1;
            end else if (dv > DEP) begin
                d = DEP; er = 1'b1;
            end else begin
                d = dv; er = 1'b0;
            end
            n++;
            hist_d[n] = d_i;
            hist_v[n] = v_i && !f_i;
            if (f_i) flush_mark = n;
            if (d != mdly) begin
                mdly  = d;
                chg_n = n;
                chg_d = d;
            end
            merr = er;
        end
        expq.push_back(model_out());
    endtask

    // Asynchronous reset pulse lasting less than one clock period
    task automatic do_reset();
        #1;
        rst        = 1'b0;
        reset_mark = n;
        mdly       = 1;
        chg_d      = 0;
        merr       = 1'b0;
        expq.delete();
        expq.push_back(model_out());
        #1;
        check("reset_dout", dout, '0);
        check("reset_dout_valid", DW'(dout_valid), '0);
        check("reset_dly_err", DW'(dly_err), '0);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare one queued expectation per clock, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("dout", dout, e.d);
                check("dout_valid", DW'(dout_valid), DW'(e.v));
                check("dly_err", DW'(dly_err), DW'(e.e));
            end
        end
    end

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    initial begin
        int cur;
        #12;
        check("init_dout", dout, '0);
        check("init_dout_valid", DW'(dout_valid), '0);
        check("init_dly_err", DW'(dly_err), '0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Fixed delay with incrementing lanes
        for (int k = 0; k < 30; k++) step(1, 0, 1, {8'(8'h80 + k), 8'(k)}, 5);

        // Reset mid-stream at delay 4
        for (int k = 0; k < 12; k++) step(1, 0, 1, rnd(), 4);
        do_reset();
        step(1, 0, 0, rnd(), 4);
        for (int k = 0; k < 15; k++) step(1, 0, 1, rnd(), 4);

        // Stall for 4 cycles at delay 3
        for (int k = 0; k < 10; k++) step(1, 0, 1, rnd(), 3);
        for (int k = 0; k < 4; k++)  step(0, 0, 1, rnd(), 3);
        for (int k = 0; k < 10; k++) step(1, 0, 1, rnd(), 3);

        // Flush with samples in flight at delay 8
        for (int k = 0; k < 12; k++) step(1, 0, 1, rnd(), 8);
        step(1, 1, 1, rnd(), 8);
        for (int k = 0; k < 20; k++) step(1, 0, 1, rnd(), 8);

        // Flush while stalled has no effect
        step(0, 1, 1, rnd(), 8);
        for (int k = 0; k < 10; k++) step(1, 0, 1, rnd(), 8);

        // Delay changes 4 -> 10 -> 2
        for (int k = 0; k < 15; k++) step(1, 0, 1, rnd(), 4);
        for (int k = 0; k < 25; k++) step(1, 0, 1, rnd(), 10);
        for (int k = 0; k < 15; k++) step(1, 0, 1, rnd(), 2);

        // Range boundaries: 0, DEPTH+3, DEPTH, and a clamp that equals the current delay
        for (int k = 0; k < 10; k++) step(1, 0, 1, rnd(), 0);
        for (int k = 0; k < 25; k++) step(1, 0, 1, rnd(), DEP + 3);
        for (int k = 0; k < 25; k++) step(1, 0, 1, rnd(), DEP);
        for (int k = 0; k < 10; k++) step(1, 0, 1, rnd(), DEP + 5);

        // Randomized traffic
        cur = 6;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 19) == 0) cur = $urandom_range(0, DEP + 4);
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0), rnd(), cur);
            if (k == 400) do_reset();
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
